// File: rtl/playback_sequencer.sv
// Playback control for the note datapath: steps through stored note slots, times each note
// and its trailing gap, gates the tone output, and supports looping, tempo scaling and abort.
module playback_sequencer #(
    parameter int unsigned NOTE_TICKS = 12500000,
    parameter int unsigned GAP_TICKS  = 1250000,
    parameter int unsigned NUM_SLOTS  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       loop_en,
    input  logic [4:0] note_count,
    input  logic [1:0] tempo_sel,
    output logic       ld_play,
    output logic       next_note_en,
    output logic [3:0] note_counter,
    output logic       tone_en,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {StIdle, StLoad, StHold, StGap, StDone} state_e;

    localparam logic [4:0]  MaxSlots  = 5'(NUM_SLOTS);
    localparam logic [31:0] NoteTicks = 32'(NOTE_TICKS);
    localparam logic [31:0] GapLast   = (GAP_TICKS == 0) ? 32'd0 : 32'(GAP_TICKS - 1);
    localparam bit          HasGap    = (GAP_TICKS != 0);

    state_e      state_q, state_d;
    logic [3:0]  index_q, index_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] dur_q, dur_d;
    logic [31:0] ctr_q, ctr_d;

    logic [4:0]  count_clamped;
    logic [31:0] dur_sel;
    logic        advance;
    logic        last_slot;

    assign count_clamped = (note_count > MaxSlots) ? MaxSlots : note_count;
    assign last_slot     = ({1'b0, index_q} == (cnt_q - 5'd1));

    always_comb begin
        unique case (tempo_sel)
            2'b00:   dur_sel = NoteTicks;
            2'b01:   dur_sel = NoteTicks << 1;
            2'b10:   dur_sel = NoteTicks >> 1;
            default: dur_sel = NoteTicks >> 2;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        cnt_d        = cnt_q;
        dur_d        = dur_q;
        ctr_d        = ctr_q;
        advance      = 1'b0;
        ld_play      = 1'b0;
        next_note_en = 1'b0;
        tone_en      = 1'b0;
        done         = 1'b0;

        unique case (state_q)
            StIdle: begin
                index_d = 4'd0;
                if (start && !stop) begin
                    cnt_d   = count_clamped;
                    state_d = (count_clamped == 5'd0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                ld_play      = 1'b1;
                next_note_en = 1'b1;
                dur_d        = dur_sel;
                ctr_d        = 32'd0;
                state_d      = StHold;
            end
            StHold: begin
                ld_play = 1'b1;
                tone_en = 1'b1;
                if (ctr_q == dur_q - 32'd1) begin
                    ctr_d = 32'd0;
                    if (HasGap) state_d = StGap;
                    else        advance = 1'b1;
                end else begin
                    ctr_d = ctr_q + 32'd1;
                end
            end
            StGap: begin
                ld_play = 1'b1;
                if (ctr_q == GapLast) begin
                    ctr_d   = 32'd0;
                    advance = 1'b1;
                end else begin
                    ctr_d = ctr_q + 32'd1;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Advance straight into the next LOAD so consecutive notes have no idle cycle.
        if (advance) begin
            if (!last_slot) begin
                index_d = index_q + 4'd1;
                state_d = StLoad;
            end else if (loop_en) begin
                index_d = 4'd0;
                state_d = StLoad;
            end else begin
                state_d = StDone;
            end
        end

        if (stop && (state_q == StLoad || state_q == StHold || state_q == StGap)) begin
            state_d = StIdle;
            index_d = 4'd0;
            ctr_d   = 32'd0;
        end
    end

    assign note_counter = index_q;
    assign busy         = ld_play;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            index_q <= 4'd0;
            cnt_q   <= 5'd0;
            dur_q   <= 32'd0;
            ctr_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            cnt_q   <= cnt_d;
            dur_q   <= dur_d;
            ctr_q   <= ctr_d;
        end
    end

endmodule

// File: tb/tb_playback_sequencer.sv
// Directed bench for playback_sequencer with NOTE_TICKS=8, GAP_TICKS=2.
module tb_playback_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       loop_en;
    logic [4:0] note_count;
    logic [1:0] tempo_sel;
    logic       ld_play;
    logic       next_note_en;
    logic [3:0] note_counter;
    logic       tone_en;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    playback_sequencer #(
        .NOTE_TICKS(8),
        .GAP_TICKS (2),
        .NUM_SLOTS (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .loop_en     (loop_en),
        .note_count  (note_count),
        .tempo_sel   (tempo_sel),
        .ld_play     (ld_play),
        .next_note_en(next_note_en),
        .note_counter(note_counter),
        .tone_en     (tone_en),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++; if (ld_play !== 1'b0) begin bad++; $display("FAIL rst_ld_play got %b want 0", ld_play); end
        total++; if (next_note_en !== 1'b0) begin bad++; $display("FAIL rst_nne got %b want 0", next_note_en); end
        total++; if (note_counter !== 4'd0) begin bad++; $display("FAIL rst_nc got %0d want 0", note_counter); end
        total++; if (tone_en !== 1'b0) begin bad++; $display("FAIL rst_tone got %b want 0", tone_en); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got %b want 0", done); end
        // Reset while a note is sounding.
        note_count = 5'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        total++; if (tone_en !== 1'b1) begin bad++; $display("FAIL midhold_tone got %b want 1", tone_en); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if ({ld_play, next_note_en, note_counter, tone_en, busy, done} !== 9'd0) begin
            bad++; $display("FAIL rst_midhold outputs got %b want 0",
                            {ld_play, next_note_en, note_counter, tone_en, busy, done});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (next_note_en !== 1'b1 || note_counter !== 4'd0) begin
            bad++; $display("FAIL rst_restart nne=%b nc=%0d want nne=1 nc=0", next_note_en, note_counter);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        note_count = 5'd3;
        tempo_sel  = 2'b00;
        loop_en    = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            logic e_nne, e_tone, e_done, e_busy;
            e_nne  = (c == 1) || (c == 12) || (c == 23);
            e_tone = (c >= 2 && c <= 9) || (c >= 13 && c <= 20) || (c >= 24 && c <= 31);
            e_done = (c == 34);
            e_busy = (c <= 33);
            total++; if (next_note_en !== e_nne) begin bad++; $display("FAIL basic_nne c=%0d got %b want %b", c, next_note_en, e_nne); end
            total++; if (tone_en !== e_tone) begin bad++; $display("FAIL basic_tone c=%0d got %b want %b", c, tone_en, e_tone); end
            total++; if (done !== e_done) begin bad++; $display("FAIL basic_done c=%0d got %b want %b", c, done, e_done); end
            total++; if (busy !== e_busy) begin bad++; $display("FAIL basic_busy c=%0d got %b want %b", c, busy, e_busy); end
            if (e_nne) begin
                total++;
                if (note_counter !== 4'((c - 1) / 11)) begin
                    bad++; $display("FAIL basic_nc c=%0d got %0d want %0d", c, note_counter, (c - 1) / 11);
                end
            end
            tick();
        end
    endtask

    task automatic test_loop();
        note_count = 5'd2;
        loop_en    = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 47; c++) begin
            logic e_nne, e_done, e_busy;
            if (c == 40) loop_en = 1'b0;
            e_nne  = (c == 1) || (c == 12) || (c == 23) || (c == 34);
            e_done = (c == 45);
            e_busy = (c <= 44);
            total++; if (next_note_en !== e_nne) begin bad++; $display("FAIL loop_nne c=%0d got %b want %b", c, next_note_en, e_nne); end
            total++; if (done !== e_done) begin bad++; $display("FAIL loop_done c=%0d got %b want %b", c, done, e_done); end
            total++; if (busy !== e_busy) begin bad++; $display("FAIL loop_busy c=%0d got %b want %b", c, busy, e_busy); end
            if (e_nne) begin
                total++;
                if (note_counter !== 4'(((c - 1) / 11) % 2)) begin
                    bad++; $display("FAIL loop_nc c=%0d got %0d want %0d", c, note_counter, ((c - 1) / 11) % 2);
                end
            end
            tick();
        end
    endtask

    task automatic test_tempo();
        note_count = 5'd2;
        loop_en    = 1'b0;
        tempo_sel  = 2'b11;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 26; c++) begin
            logic e_tone, e_done;
            if (c == 2) tempo_sel = 2'b01;
            e_tone = (c >= 2 && c <= 3) || (c >= 7 && c <= 22);
            e_done = (c == 25);
            total++; if (tone_en !== e_tone) begin bad++; $display("FAIL tempo_tone c=%0d got %b want %b", c, tone_en, e_tone); end
            total++; if (done !== e_done) begin bad++; $display("FAIL tempo_done c=%0d got %b want %b", c, done, e_done); end
            tick();
        end
        tempo_sel = 2'b00;
    endtask

    task automatic test_stop();
        int done_seen;
        note_count = 5'd3;
        loop_en    = 1'b0;
        tempo_sel  = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 16; c++) tick();
        total++; if (tone_en !== 1'b1 || note_counter !== 4'd1) begin
            bad++; $display("FAIL stop_pre tone=%b nc=%0d want tone=1 nc=1", tone_en, note_counter);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        total++; if (tone_en !== 1'b0) begin bad++; $display("FAIL stop_tone got %b want 0", tone_en); end
        total++; if (ld_play !== 1'b0) begin bad++; $display("FAIL stop_ld_play got %b want 0", ld_play); end
        total++; if (note_counter !== 4'd0) begin bad++; $display("FAIL stop_nc got %0d want 0", note_counter); end
        done_seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (done === 1'b1) done_seen++;
            tick();
        end
        total++; if (done_seen !== 0) begin bad++; $display("FAIL stop_done got %0d pulses want 0", done_seen); end
        start = 1'b1;
        stop  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (busy !== 1'b0 || next_note_en !== 1'b0 || done !== 1'b0) begin
                bad++; $display("FAIL startstop c=%0d busy=%b nne=%b done=%b want 0", c, busy, next_note_en, done);
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        tick();
    endtask

    task automatic test_empty();
        int n_done, n_nne;
        note_count = 5'd0;
        n_done = 0;
        n_nne  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (done === 1'b1) n_done++;
            if (next_note_en === 1'b1) n_nne++;
            tick();
        end
        total++; if (n_done !== 1) begin bad++; $display("FAIL empty_done got %0d want 1", n_done); end
        total++; if (n_nne !== 0) begin bad++; $display("FAIL empty_nne got %0d want 0", n_nne); end
    endtask

    task automatic test_overflow();
        int loads, done_cyc;
        note_count = 5'd20;
        tempo_sel  = 2'b11;
        loop_en    = 1'b0;
        loads    = 0;
        done_cyc = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 90; c++) begin
            if (c == 30) note_count = 5'd2;
            if (next_note_en === 1'b1) begin
                total++;
                if (note_counter !== 4'(loads)) begin
                    bad++; $display("FAIL ovf_nc c=%0d got %0d want %0d", c, note_counter, loads);
                end
                loads++;
            end
            if (done === 1'b1 && done_cyc < 0) done_cyc = c;
            tick();
        end
        total++; if (loads !== 16) begin bad++; $display("FAIL ovf_loads got %0d want 16", loads); end
        total++; if (done_cyc !== 81) begin bad++; $display("FAIL ovf_done_cycle got %0d want 81", done_cyc); end
        tempo_sel = 2'b00;
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        loop_en    = 1'b0;
        note_count = 5'd0;
        tempo_sel  = 2'b00;
        test_reset();
        test_basic();
        test_loop();
        test_tempo();
        test_stop();
        test_empty();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
